// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM/WB types and constants for the MIPS pipeline
package mips_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    typedef enum logic {IDLE, WAIT} dmem_state_e;
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;
    localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};
endpackage

// File: rtl/dmem_handshake_fsm.sv
// dmem_handshake_fsm: data-memory request/ack sequencing and pipeline stall
// Optional watchdog abort of a stuck access under DMEM_TIMEOUT_EN.
module dmem_handshake_fsm
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic access_i,
    input  logic ack_i,
    output logic req_o,
    output logic stall_o,
    output logic abort_o
);
    dmem_state_e state_q, state_d;
`ifdef DMEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif
    always_comb begin
        state_d = state_q;
        req_o   = 1'b0;
        stall_o = 1'b0;
        abort_o = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (!reset) begin
            if (state_q == IDLE) begin
                req_o   = access_i;
                stall_o = access_i && !ack_i;
`ifdef DMEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end else begin
                req_o   = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                abort_o = !ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
                cnt_d   = cnt_q + 1'b1;
`endif
                stall_o = !ack_i && !abort_o;
            end
            state_d = stall_o ? WAIT : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: rtl/mem_stage_wb_register.sv
// mem_stage_wb_register: MIPS MEM stage with MEM/WB register and stall accounting
// Define DMEM_TIMEOUT_EN to enable the access watchdog and sticky bus_err_o.
module mem_stage_wb_register
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH      = mips_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_read_i,
    input  logic                       mem_write_i,
    input  logic                       mem_to_reg_i,
    input  logic                       reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0]  write_register_i,
    input  logic [DATA_WIDTH-1:0]      alu_result_i,
    input  logic [DATA_WIDTH-1:0]      read_data_2_i,
    output logic                       dmem_req_o,
    output logic                       dmem_we_o,
    output logic [DATA_WIDTH-1:0]      dmem_addr_o,
    output logic [DATA_WIDTH-1:0]      dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata_i,
    input  logic                       dmem_ack_i,
    output logic                       stall_o,
    output logic                       reg_write_o,
    output logic                       mem_to_reg_o,
    output logic [REG_ADDR_WIDTH-1:0]  write_register_o,
    output logic [DATA_WIDTH-1:0]      alu_result_o,
    output logic [DATA_WIDTH-1:0]      read_data_o,
    output logic [DATA_WIDTH-1:0]      wb_data_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_o,
    output logic                       bus_err_o
);
    logic abort, load_done;
    logic [DATA_WIDTH-1:0] load_data;
    wb_ctrl_t ctrl_q, ctrl_d;
    logic [REG_ADDR_WIDTH-1:0] write_register_q, write_register_d;
    logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d, read_data_q, read_data_d, wb_data_q, wb_data_d;
    logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    dmem_handshake_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .access_i (mem_read_i | mem_write_i),
        .ack_i    (dmem_ack_i),
        .req_o    (dmem_req_o),
        .stall_o  (stall_o),
        .abort_o  (abort)
    );
    assign dmem_we_o    = mem_write_i;
    assign dmem_addr_o  = alu_result_i;
    assign dmem_wdata_o = read_data_2_i;
    // An ack without an outstanding request never reaches the WB data path.
    assign load_done = mem_read_i && !mem_write_i && dmem_req_o && dmem_ack_i;
    assign load_data = load_done ? dmem_rdata_i : '0;
    always_comb begin
        ctrl_d           = stall_o ? WB_BUBBLE : '{reg_write: reg_write_i && !abort, mem_to_reg: mem_to_reg_i};
        write_register_d = stall_o ? '0 : write_register_i;
        alu_result_d     = stall_o ? '0 : alu_result_i;
        read_data_d      = stall_o ? '0 : load_data;
        wb_data_d        = stall_o ? '0 : (mem_to_reg_i ? load_data : alu_result_i);
        stall_count_d    = (stall_o && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q           <= WB_BUBBLE;
            write_register_q <= '0;
            alu_result_q     <= '0;
            read_data_q      <= '0;
            wb_data_q        <= '0;
            stall_count_q    <= '0;
        end else begin
            ctrl_q           <= ctrl_d;
            write_register_q <= write_register_d;
            alu_result_q     <= alu_result_d;
            read_data_q      <= read_data_d;
            wb_data_q        <= wb_data_d;
            stall_count_q    <= stall_count_d;
        end
    end
`ifdef DMEM_TIMEOUT_EN
    logic bus_err_q, bus_err_d;
    assign bus_err_d = bus_err_q | abort;
    always_ff @(posedge clk) begin
        if (reset) bus_err_q <= 1'b0;
        else bus_err_q <= bus_err_d;
    end
    assign bus_err_o = bus_err_q;
`else
    assign bus_err_o = 1'b0;
`endif
    assign reg_write_o      = ctrl_q.reg_write;
    assign mem_to_reg_o     = ctrl_q.mem_to_reg;
    assign write_register_o = write_register_q;
    assign alu_result_o     = alu_result_q;
    assign read_data_o      = read_data_q;
    assign wb_data_o        = wb_data_q;
    assign stall_count_o    = stall_count_q;
endmodule

// File: tb/tb_mem_stage_wb_register.sv
// tb_mem_stage_wb_register: scoreboard bench for the MEM stage and MEM/WB register
module tb_mem_stage_wb_register;
    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] wb;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1;
    logic mem_read_i = 0, mem_write_i = 0, mem_to_reg_i = 0, reg_write_i = 0;
    logic [4:0] write_register_i = 0;
    logic [31:0] alu_result_i = 0, read_data_2_i = 0, dmem_rdata_i = 0;
    logic dmem_ack_i = 0;
    logic dmem_req_o, dmem_we_o, stall_o, reg_write_o, mem_to_reg_o, bus_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, alu_result_o, read_data_o, wb_data_o;
    logic [4:0] write_register_o;
    logic [15:0] stall_count_o;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0, exp_cnt = 0;
    mem_stage_wb_register #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
        .write_register_i(write_register_i), .alu_result_i(alu_result_i),
        .read_data_2_i(read_data_2_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .stall_o(stall_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
        .write_register_o(write_register_o), .alu_result_o(alu_result_o),
        .read_data_o(read_data_o), .wb_data_o(wb_data_o),
        .stall_count_o(stall_count_o), .bus_err_o(bus_err_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [127:0] wb_now();
        return 128'({reg_write_o, mem_to_reg_o, write_register_o, alu_result_o, read_data_o, wb_data_o});
    endfunction
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(tag, wb_now(), 128'(e));
        end
    endtask
    task automatic set_in(input logic rw, m2r, input logic [4:0] wr, input logic [31:0] alu, wd,
                          input logic rd_f, wr_f);
        reg_write_i = rw; mem_to_reg_i = m2r; write_register_i = wr;
        alu_result_i = alu; read_data_2_i = wd; mem_read_i = rd_f; mem_write_i = wr_f;
    endtask
    // Runs one instruction through MEM; ack arrives after `waits` stall cycles.
    task automatic op(input string tag, input logic rw, m2r, input logic [4:0] wr,
                      input logic [31:0] alu, wd, input logic rd_f, wr_f,
                      input int waits, input logic [31:0] rdata);
        logic acc, stl;
        logic [31:0] rdv;
        set_in(rw, m2r, wr, alu, wd, rd_f, wr_f);
        acc = rd_f | wr_f;
        for (int k = 0; k <= waits; k++) begin
            dmem_ack_i = (k == waits);
            dmem_rdata_i = (k == waits) ? rdata : 32'hDEAD_0000 + k;
            #1;
            stl = acc && (k < waits);
            chk({tag, "_stall"}, 128'(stall_o), 128'(stl));
            chk({tag, "_req"}, 128'(dmem_req_o), 128'(acc));
            if (acc) begin
                chk({tag, "_we"}, 128'(dmem_we_o), 128'(wr_f));
                chk({tag, "_addr"}, 128'(dmem_addr_o), 128'(alu));
                chk({tag, "_wdata"}, 128'(dmem_wdata_o), 128'(wd));
            end
            rdv = (rd_f && !wr_f) ? rdata : 32'h0;
            if (stl) begin
                sb.push_back('0);
                exp_cnt++;
            end else sb.push_back('{rw: rw, m2r: m2r, wr: wr, alu: alu, rd: rdv, wb: m2r ? rdv : alu});
            @(posedge clk);
            #1;
            pop_check({tag, "_wb"});
        end
        dmem_ack_i = 0;
        chk({tag, "_scnt"}, 128'(stall_count_o), 128'(exp_cnt));
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 128'(dmem_req_o), 128'(0));
        chk("rst_stall", 128'(stall_o), 128'(0));
        chk("rst_wb", wb_now(), 128'(0));
        chk("rst_scnt", 128'(stall_count_o), 128'(0));
        chk("rst_berr", 128'(bus_err_o), 128'(0));
        reset = 0;
        op("alu", 1, 0, 5, 32'h10, 32'h0, 0, 0, 0, 32'h5555_AAAA);
        op("ld0", 1, 1, 8, 32'h100, 32'h0, 1, 0, 0, 32'hCAFE_BABE);
        op("ld3", 1, 1, 9, 32'h104, 32'h0, 1, 0, 3, 32'h0BAD_F00D);
        op("st1", 0, 0, 0, 32'h200, 32'h1234_5678, 0, 1, 1, 32'hFFFF_FFFF);
        op("rdwr", 0, 1, 3, 32'h204, 32'h0000_00A5, 1, 1, 0, 32'h7777_7777);
        op("alu2", 1, 0, 31, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 32'h0);
        // Reset lands in the second WAIT cycle of a stuck load.
        set_in(1, 1, 7, 32'h300, 32'h0, 1, 0);
        dmem_ack_i = 0;
        #1;
        chk("rw_stall0", 128'(stall_o), 128'(1));
        @(posedge clk); #1;
        chk("rw_bub0", 128'(reg_write_o), 128'(0));
        @(posedge clk); #1;
        chk("rw_bub1", 128'(reg_write_o), 128'(0));
        reset = 1;
        #1;
        chk("rw_req_in_rst", 128'(dmem_req_o), 128'(0));
        @(posedge clk); #1;
        reset = 0;
        set_in(0, 0, 0, 32'h0, 32'h0, 0, 0);
        #1;
        chk("rw_req", 128'(dmem_req_o), 128'(0));
        chk("rw_stall", 128'(stall_o), 128'(0));
        chk("rw_wb", wb_now(), 128'(0));
        chk("rw_scnt", 128'(stall_count_o), 128'(0));
        exp_cnt = 0;
        op("post_rst", 1, 0, 12, 32'h44, 32'h0, 0, 0, 0, 32'h0);
`ifdef DMEM_TIMEOUT_EN
        set_in(1, 1, 6, 32'h400, 32'h0, 1, 0);
        dmem_ack_i = 0;
        for (int k = 0; k <= 4; k++) begin
            #1;
            chk("to_stall", 128'(stall_o), 128'(k < 4));
            if (k < 4) begin
                sb.push_back('0);
                exp_cnt++;
            end else sb.push_back('{rw: 1'b0, m2r: 1'b1, wr: 5'd6, alu: 32'h400, rd: 32'h0, wb: 32'h0});
            @(posedge clk); #1;
            pop_check("to_wb");
        end
        chk("to_berr", 128'(bus_err_o), 128'(1));
        op("to_resume", 1, 0, 2, 32'h88, 32'h0, 0, 0, 0, 32'h0);
        chk("to_berr_sticky", 128'(bus_err_o), 128'(1));
`else
        chk("berr_tied", 128'(bus_err_o), 128'(0));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
